// File: rtl/tinyalu_cmd_driver_if.sv
// Command/response handshake bundle between a requester and tinyalu_cmd_driver.
// rsp_timeout exists only when TINYALU_CMD_TIMEOUT_EN is defined.
interface tinyalu_cmd_driver_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_a;
   logic [7:0]  cmd_b;
   logic [2:0]  cmd_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic [2:0]  rsp_op;
`ifdef TINYALU_CMD_TIMEOUT_EN
   logic        rsp_timeout;
`endif

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
`ifdef TINYALU_CMD_TIMEOUT_EN
      input  rsp_timeout,
`endif
      input  cmd_ready, rsp_valid, rsp_result, rsp_op
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
`ifdef TINYALU_CMD_TIMEOUT_EN
      output rsp_timeout,
`endif
      output cmd_ready, rsp_valid, rsp_result, rsp_op
   );
endinterface

// File: rtl/tinyalu_cmd_driver.sv
// Synthesizable TinyALU front-end: command FIFO, start/done sequencer, response register.
// Optional ALU watchdog enabled by defining TINYALU_CMD_TIMEOUT_EN.
module tinyalu_cmd_driver #(
   parameter int DEPTH      = 4,
   parameter int RST_CYCLES = 2,
   parameter int TIMEOUT    = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   tinyalu_cmd_driver_if.slave          bus,
   output logic [7:0]                   alu_a,
   output logic [7:0]                   alu_b,
   output logic [2:0]                   alu_op,
   output logic                         alu_start,
   output logic                         alu_reset_n,
   input  logic                         alu_done,
   input  logic [15:0]                  alu_result,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH+1);
   localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_RST = 3'b111;

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
   } cmd_t;

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_NOP, S_GAP, S_ARST, S_RESP} state_t;

   // ---------------- command FIFO ----------------
   cmd_t            mem_q [DEPTH];
   cmd_t            mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            cmd_ready;
   logic            enq;
   logic            pop;
   cmd_t            head;

   // Ready looks only at occupancy so a full FIFO never takes a push on its pop cycle.
   assign cmd_ready = !reset && (count_q != CW'(DEPTH));
   assign enq       = bus.cmd_valid && cmd_ready &&
                      (bus.cmd_op != 3'b101) && (bus.cmd_op != 3'b110);
   assign head      = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(enq) - CW'(pop);
      if (enq) begin
         mem_d[wr_ptr_q] = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // ---------------- sequencer ----------------
   state_t          state_q, state_d;
   logic [7:0]      alu_a_q, alu_a_d;
   logic [7:0]      alu_b_q, alu_b_d;
   logic [2:0]      alu_op_q, alu_op_d;
   logic            alu_start_q, alu_start_d;
   logic            alu_reset_n_q, alu_reset_n_d;
   logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [15:0]     rsp_result_q, rsp_result_d;
   logic [2:0]      rsp_op_q, rsp_op_d;
`ifdef TINYALU_CMD_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT+1);
   logic [WDW-1:0]  wd_q, wd_d;
   logic            to_pend_q, to_pend_d;
   logic            rsp_to_q, rsp_to_d;
`endif

   always_comb begin
      state_d       = state_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_op_d      = alu_op_q;
      alu_start_d   = alu_start_q;
      alu_reset_n_d = 1'b1;
      rst_cnt_d     = rst_cnt_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_result_d  = rsp_result_q;
      rsp_op_d      = rsp_op_q;
      pop           = 1'b0;
`ifdef TINYALU_CMD_TIMEOUT_EN
      wd_d          = wd_q;
      to_pend_d     = to_pend_q;
      rsp_to_d      = rsp_to_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop      = 1'b1;
               alu_a_d  = head.a;
               alu_b_d  = head.b;
               alu_op_d = head.op;
               if (head.op == OP_RST) begin
                  alu_start_d   = 1'b0;
                  alu_reset_n_d = 1'b0;
                  rst_cnt_d     = RCW'(RST_CYCLES-1);
                  state_d       = S_ARST;
               end else if (head.op == OP_NOP) begin
                  alu_start_d = 1'b1;
                  state_d     = S_NOP;
               end else begin
                  alu_start_d = 1'b1;
                  state_d     = S_RUN;
`ifdef TINYALU_CMD_TIMEOUT_EN
                  wd_d        = '0;
`endif
               end
            end
         end
         S_RUN: begin
            if (alu_done) begin
               alu_start_d  = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_result_d = alu_result;
               rsp_op_d     = alu_op_q;
`ifdef TINYALU_CMD_TIMEOUT_EN
               rsp_to_d     = 1'b0;
            end else if (wd_q == WDW'(TIMEOUT-1)) begin
               // ALU hung: pull start, reset it, then report a failed result.
               alu_start_d   = 1'b0;
               alu_reset_n_d = 1'b0;
               rst_cnt_d     = RCW'(RST_CYCLES-1);
               to_pend_d     = 1'b1;
               state_d       = S_ARST;
            end else begin
               wd_d = wd_q + WDW'(1);
`endif
            end
            if (alu_done) state_d = S_RESP;
         end
         S_NOP: begin
            alu_start_d = 1'b0;
            state_d     = S_GAP;
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         S_ARST: begin
            if (rst_cnt_q == '0) begin
               state_d = S_GAP;
`ifdef TINYALU_CMD_TIMEOUT_EN
               if (to_pend_q) begin
                  to_pend_d    = 1'b0;
                  rsp_valid_d  = 1'b1;
                  rsp_result_d = 16'hFFFF;
                  rsp_op_d     = alu_op_q;
                  rsp_to_d     = 1'b1;
                  state_d      = S_RESP;
               end
`endif
            end else begin
               alu_reset_n_d = 1'b0;
               rst_cnt_d     = rst_cnt_q - RCW'(1);
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_op_q      <= '0;
         alu_start_q   <= 1'b0;
         alu_reset_n_q <= 1'b0;
         rst_cnt_q     <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_result_q  <= '0;
         rsp_op_q      <= '0;
`ifdef TINYALU_CMD_TIMEOUT_EN
         wd_q          <= '0;
         to_pend_q     <= 1'b0;
         rsp_to_q      <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_op_q      <= alu_op_d;
         alu_start_q   <= alu_start_d;
         alu_reset_n_q <= alu_reset_n_d;
         rst_cnt_q     <= rst_cnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_result_q  <= rsp_result_d;
         rsp_op_q      <= rsp_op_d;
`ifdef TINYALU_CMD_TIMEOUT_EN
         wd_q          <= wd_d;
         to_pend_q     <= to_pend_d;
         rsp_to_q      <= rsp_to_d;
`endif
      end
   end

   assign bus.cmd_ready  = cmd_ready;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_op     = rsp_op_q;
`ifdef TINYALU_CMD_TIMEOUT_EN
   assign bus.rsp_timeout = rsp_to_q;
`endif
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign alu_start   = alu_start_q;
   assign alu_reset_n = alu_reset_n_q;
   assign fifo_count  = count_q;

endmodule

// File: tb/tb_tinyalu_cmd_driver.sv
// Directed bench for tinyalu_cmd_driver with a behavioural TinyALU (done after lat clocks of start).
module tb_tinyalu_cmd_driver;
   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  alu_a, alu_b;
   logic [2:0]  alu_op;
   logic        alu_start, alu_reset_n, alu_done;
   logic [15:0] alu_result;
   logic [2:0]  fifo_count;

   int checks = 0;
   int errors = 0;

   tinyalu_cmd_driver_if bus ();

   tinyalu_cmd_driver #(.DEPTH(4), .RST_CYCLES(2), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_start(alu_start), .alu_reset_n(alu_reset_n),
      .alu_done(alu_done), .alu_result(alu_result),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   // ---------------- ALU model ----------------
   int   lat = 1;
   int   sc = 0;
   logic no_done = 1'b0;

   always_comb begin
      case (alu_op)
         3'b001:  alu_result = {8'h00, alu_a} + {8'h00, alu_b};
         3'b010:  alu_result = {8'h00, alu_a & alu_b};
         3'b011:  alu_result = {8'h00, alu_a ^ alu_b};
         3'b100:  alu_result = {8'h00, alu_a} * {8'h00, alu_b};
         default: alu_result = 16'h0000;
      endcase
   end

   always @(posedge clk) begin
      if (!alu_start || !alu_reset_n || alu_op == 3'b000 || no_done) begin
         sc       <= 0;
         alu_done <= 1'b0;
      end else begin
         sc       <= sc + 1;
         alu_done <= (sc + 1 == lat);
      end
   end

   // ---------------- pin monitors ----------------
   int   cyc = 0;
   int   start_run = 0;
   int   rstn_run = 0;
   logic start_prev = 1'b0;
   int   start_lens[$];
   int   rstn_lens[$];
   int   rise[$];

   always @(posedge clk) begin
      cyc        <= cyc + 1;
      start_prev <= alu_start;
      if (alu_start && !start_prev) rise.push_back(cyc);
      if (alu_start) start_run <= start_run + 1;
      else if (start_run > 0) begin
         start_lens.push_back(start_run);
         start_run <= 0;
      end
      if (!alu_reset_n) rstn_run <= rstn_run + 1;
      else if (rstn_run > 0) begin
         rstn_lens.push_back(rstn_run);
         rstn_run <= 0;
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      int n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_op    = op;
      while (!bus.cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) chk("push_wait", 32'(bus.cmd_ready), 32'd1);
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic [15:0] r, output logic [2:0] o);
      int n = 0;
      bus.rsp_ready = 1'b1;
      while (!bus.rsp_valid && n < 100) begin
         tick();
         n++;
      end
      chk("rsp_wait", 32'(bus.rsp_valid), 32'd1);
      r = bus.rsp_result;
      o = bus.rsp_op;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [2:0]  op;
      logic [15:0] exp;
   } vec_t;

   vec_t        vecs[8];
   logic [15:0] r;
   logic [2:0]  o;
   int          n;
   int          expv[4];

   initial begin
      vecs[0] = '{8'h00, 8'h00, 3'b001, 16'h0000};
      vecs[1] = '{8'hFF, 8'hFF, 3'b001, 16'h01FE};
      vecs[2] = '{8'hFF, 8'h0F, 3'b010, 16'h000F};
      vecs[3] = '{8'hF0, 8'hFF, 3'b011, 16'h000F};
      vecs[4] = '{8'h10, 8'h10, 3'b100, 16'h0100};
      vecs[5] = '{8'h80, 8'h02, 3'b100, 16'h0100};
      vecs[6] = '{8'h7F, 8'h01, 3'b001, 16'h0080};
      vecs[7] = '{8'h00, 8'hFF, 3'b100, 16'h0000};

      reset = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_a = '0;
      bus.cmd_b = '0;
      bus.cmd_op = '0;
      bus.rsp_ready = 1'b0;

      // reset held 3 clocks, then release
      repeat (3) tick();
      chk("rst_alu_reset_n", 32'(alu_reset_n), 32'd0);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      chk("rst_outs", {alu_start, bus.rsp_valid, alu_op, alu_a, alu_b}, 32'd0);
      reset = 1'b0;
      tick();
      chk("rel_alu_reset_n", 32'(alu_reset_n), 32'd1);
      chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      // add FF+01, cycle by cycle
      push(8'hFF, 8'h01, 3'b001);
      chk("add_queued", {fifo_count, 7'd0, alu_start}, {3'd1, 7'd0, 1'b0});
      tick();
      chk("add_issue", {alu_start, alu_op, alu_a, alu_b}, {1'b1, 3'b001, 8'hFF, 8'h01});
      chk("add_popped", 32'(fifo_count), 32'd0);
      tick();
      chk("add_start_held", {alu_start, bus.rsp_valid}, 2'b10);
      tick();
      chk("add_rsp", {alu_start, bus.rsp_valid, bus.rsp_op, bus.rsp_result}, {1'b0, 1'b1, 3'b001, 16'h0100});
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("add_rsp_drop", 32'(bus.rsp_valid), 32'd0);

      // mul then xor with back-pressure for 10 clocks
      push(8'hFF, 8'hFF, 3'b100);
      push(8'hAA, 8'h55, 3'b011);
      n = 0;
      while (!bus.rsp_valid && n < 50) begin tick(); n++; end
      for (int i = 0; i < 10; i++) begin
         chk("mul_hold", {bus.rsp_valid, alu_start, bus.rsp_result}, {1'b1, 1'b0, 16'hFE01});
         tick();
      end
      get_rsp(r, o);
      chk("mul_rsp", {o, r}, {3'b100, 16'hFE01});
      get_rsp(r, o);
      chk("xor_rsp", {o, r}, {3'b011, 16'h00FF});

      // five back-to-back pushes fill the FIFO behind one in-flight command
      for (int i = 0; i < 5; i++) push(8'(i + 1), 8'(i + 1), 3'b001);
      chk("full_count", 32'(fifo_count), 32'd4);
      chk("full_ready", 32'(bus.cmd_ready), 32'd0);
      chk("full_rsp0", {bus.rsp_valid, bus.rsp_result}, {1'b1, 16'h0002});
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("full_ready_popcyc", {fifo_count, 7'd0, bus.cmd_ready}, {3'd4, 7'd0, 1'b0});
      bus.cmd_valid = 1'b1;
      bus.cmd_a = 8'h09;
      bus.cmd_b = 8'h09;
      bus.cmd_op = 3'b001;
      tick();
      bus.cmd_valid = 1'b0;
      chk("full_no_push_on_pop", 32'(fifo_count), 32'd3);
      expv = '{4, 6, 8, 10};
      for (int i = 0; i < 4; i++) begin
         get_rsp(r, o);
         chk("full_order", 32'(r), 32'(expv[i]));
      end

      // no_op, rst_op, and
      tick();
      start_lens.delete();
      rstn_lens.delete();
      push(8'h00, 8'h00, 3'b000);
      push(8'h00, 8'h00, 3'b111);
      push(8'hF0, 8'h3C, 3'b010);
      get_rsp(r, o);
      tick();
      chk("seq_and_rsp", {o, r}, {3'b010, 16'h0030});
      chk("seq_start_pulses", 32'(start_lens.size()), 32'd2);
      chk("seq_nop_len", (start_lens.size() > 0) ? 32'(start_lens[0]) : 32'hFFFF, 32'd1);
      chk("seq_rst_len", (rstn_lens.size() == 1) ? 32'(rstn_lens[0]) : 32'hFFFF, 32'd2);

      // table of ALU operations
      for (int i = 0; i < 8; i++) begin
         push(vecs[i].a, vecs[i].b, vecs[i].op);
         get_rsp(r, o);
         chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].exp));
         chk($sformatf("vec%0d_op", i), 32'(o), 32'(vecs[i].op));
      end

      // reserved opcode is accepted but dropped
      push(8'h11, 8'h22, 3'b101);
      chk("op101_count", 32'(fifo_count), 32'd0);
      repeat (3) tick();
      chk("op101_idle", {alu_start, bus.rsp_valid}, 2'b00);

      // throughput with rsp_ready held high
      rise.delete();
      bus.rsp_ready = 1'b1;
      push(8'h01, 8'h02, 3'b001);
      push(8'h03, 8'h04, 3'b001);
      push(8'h05, 8'h06, 3'b001);
      bus.rsp_ready = 1'b1;
      repeat (20) tick();
      bus.rsp_ready = 1'b0;
      chk("thr_starts", 32'(rise.size()), 32'd3);
      chk("thr_gap1", (rise.size() >= 2) ? 32'(rise[1] - rise[0]) : 32'hFFFF, 32'd4);
      chk("thr_gap2", (rise.size() >= 3) ? 32'(rise[2] - rise[1]) : 32'hFFFF, 32'd4);

      // reset in the middle of an operation
      lat = 6;
      push(8'h01, 8'h02, 3'b001);
      push(8'h03, 8'h04, 3'b001);
      n = 0;
      while (!alu_start && n < 20) begin tick(); n++; end
      tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_pins", {alu_start, alu_reset_n, bus.rsp_valid}, 3'b000);
      chk("mid_rst_fifo", 32'(fifo_count), 32'd0);
      reset = 1'b0;
      lat = 1;
      tick();
      chk("mid_rst_release", {alu_reset_n, bus.cmd_ready}, 2'b11);
      repeat (8) tick();
      chk("mid_rst_no_rsp", {alu_start, bus.rsp_valid}, 2'b00);
      push(8'h20, 8'h22, 3'b001);
      get_rsp(r, o);
      chk("mid_rst_after", 32'(r), 32'h0042);

`ifdef TINYALU_CMD_TIMEOUT_EN
      chk("to_normal_flag", 32'(bus.rsp_timeout), 32'd0);
      tick();
      no_done = 1'b1;
      start_lens.delete();
      rstn_lens.delete();
      push(8'h01, 8'h01, 3'b001);
      get_rsp(r, o);
      tick();
      no_done = 1'b0;
      chk("to_result", {bus.rsp_timeout, 3'd0, r}, {1'b1, 3'd0, 16'hFFFF});
      chk("to_start_len", (start_lens.size() == 1) ? 32'(start_lens[0]) : 32'hFFFF, 32'd16);
      chk("to_rst_len", (rstn_lens.size() == 1) ? 32'(rstn_lens[0]) : 32'hFFFF, 32'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tinyalu_cmd_driver.md
Name: tinyalu_cmd_driver

Overview:
- RTL command front-end sitting directly upstream of the TinyALU.
- Accepts operations over a valid/ready command port and buffers them in a small FIFO.
- Drives the ALU A/B/op/start/reset_n pins with the ALU start/done protocol.
- Returns each result over a valid/ready response port. Replaces the testbench-only driver task so the ALU can be exercised by synthesizable logic.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, minimum 2.
- RST_CYCLES, 2: clocks alu_reset_n is held low for an rst_op command.
- TIMEOUT, 16: max clocks start may stay high awaiting done. Used only with the optional feature.

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid and ready both high
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_op  in  3  000 no_op, 001 add, 010 and, 011 xor, 100 mul, 111 rst_op
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_result  out  16  ALU result
- rsp_op  out  3  opcode that produced rsp_result
- alu_a  out  8  to ALU A
- alu_b  out  8  to ALU B
- alu_op  out  3  to ALU op
- alu_start  out  1  to ALU start
- alu_reset_n  out  1  to ALU reset_n
- alu_done  in  1  from ALU done
- alu_result  in  16  from ALU result
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (sync, while reset=1):
  - FIFO flushed, FSM to IDLE.
  - alu_start=0, alu_reset_n=0, alu_a/alu_b/alu_op=0.
  - rsp_valid=0, rsp_result=0, rsp_op=0, fifo_count=0, cmd_ready=0.
- First clock after reset deasserts: alu_reset_n=1, cmd_ready=1.
- cmd_ready = !reset && fifo_count!=DEPTH.
  - Depends only on occupancy, so a same-cycle pop does not admit a push when full.
- Opcodes 101/110 are accepted (handshake completes) but not enqueued. No ALU activity, no response.
- Simultaneous push and pop: count unchanged, ordering preserved. Pointers wrap modulo DEPTH.
- FSM states: IDLE, RUN, NOP, GAP, ARST, RESP. All ALU outputs are registered.
- IDLE:
  - FIFO non-empty: pop head, load alu_a/alu_b/alu_op.
  - add/and/xor/mul: alu_start=1 next cycle, go RUN.
  - no_op: alu_start=1, go NOP.
  - rst_op: alu_start=0, alu_reset_n=0, go ARST.
  - Fetch-to-start latency is 1 clock.
- RUN:
  - alu_start held 1 and operands/op held stable until alu_done sampled 1 at posedge.
  - That edge: capture alu_result into rsp_result and alu_op into rsp_op, set rsp_valid=1, alu_start=0, go RESP.
- NOP: alu_start high exactly 1 clock, then 0, go GAP. No response.
- GAP: one clock with alu_start=0, then IDLE. Guarantees start low ≥1 clock between commands.
- ARST: alu_reset_n low exactly RST_CYCLES clocks, then 1, go GAP. No response.
- RESP:
  - alu_start=0. rsp_valid, rsp_result and rsp_op held stable until rsp_ready=1.
  - On accept: rsp_valid=0 next cycle, go IDLE.
  - RESP also satisfies the start-low gap.
- Back-pressure: while in RESP the FSM does not fetch. FIFO keeps filling up to DEPTH.
- Throughput with rsp_ready tied 1: one add every 4 clocks (issue, done, RESP, next issue), given a 1-cycle ALU done.
- Reset mid-operation: abandons the in-flight command, drops the response, flushes the FIFO. alu_reset_n goes low in the same cycle.
- No combinational path from alu_done or rsp_ready to any output.

Optional Feature:
- Macro TINYALU_CMD_TIMEOUT_EN.
- Defined:
  - A watchdog counter starts on entry to RUN and increments each clock.
  - If alu_done has not been seen after TIMEOUT clocks: drop alu_start, run ARST for RST_CYCLES, then present a response with rsp_result=16'hFFFF and added output port rsp_timeout=1.
  - rsp_timeout=0 on all normal responses; reset value 0.
- Undefined: no counter and no rsp_timeout port. RUN waits for alu_done indefinitely.

Test Plan:
- Reset held 3 clocks, then release -> during reset alu_reset_n=0, cmd_ready=0, fifo_count=0; one clock after release alu_reset_n=1, cmd_ready=1.
- add A=8'hFF B=8'h01, rsp_ready=1 -> alu_start rises 1 clock after fetch and stays high until done. Response rsp_result=16'h0100, rsp_op=001. alu_start low ≥1 clock before next start.
- mul A=8'hFF B=8'hFF followed by xor 8'hAA^8'h55 with rsp_ready=0 for 10 clocks -> rsp_result 16'hFE01 held stable all 10 clocks; xor not started until accept. Then 16'h00FF.
- Push 5 commands back-to-back with DEPTH=4 and rsp_ready=0 -> 1 fetched, then FIFO fills. cmd_ready=0 when fifo_count=4 and stays 0 on the pop cycle. All responses later return in push order.
- no_op then rst_op then and 8'hF0&8'h3C -> no_op start is exactly 1 clock with no response. alu_reset_n low exactly RST_CYCLES=2 clocks. Single response 16'h0030.
- With TINYALU_CMD_TIMEOUT_EN, alu_done tied 0, add issued -> start drops after 16 clocks, alu_reset_n low 2 clocks. Response rsp_result=16'hFFFF, rsp_timeout=1.
